cascade_counter_ctl: RTL and testbench

- Parametrised successor to the fixed three-stage cascaded counter controller.
- Chains STAGES counter digits of WIDTH bits. Each digit wraps at LIMIT. Count direction is selectable.
- A 4-state FSM sequences run, pause and terminal states, with parallel load and per-stage carry outputs.
- Sits in the control/sequencer layer. Drives downstream timing/decode logic from a single clock.

---
 rtl/cascade_counter_ctl.sv | 127 ++++++++++++
 tb/tb_cascade_counter_ctl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cascade_counter_ctl.sv
// Parametrised cascaded digit counter with run/pause/done sequencing FSM.
// Optional CASCADE_PARITY_EN adds a registered even-parity output PAR.
module cascade_counter_ctl #(
  parameter int STAGES       = 3,
  parameter int WIDTH        = 4,
  parameter int LIMIT        = 9,
  parameter int AUTO_RESTART = 0
) (
  input  logic                      CK,
  input  logic                      RSTN,
  input  logic                      START,
  input  logic                      HOLD,
  input  logic                      CLR,
  input  logic                      DIR,
  input  logic                      LOAD,
  input  logic [STAGES*WIDTH-1:0]   LOAD_VAL,
  output logic [STAGES*WIDTH-1:0]   CNT,
  output logic [STAGES-1:0]         CARRY,
  output logic [1:0]                STATE,
  output logic                      BUSY,
  output logic                      DONE
`ifdef CASCADE_PARITY_EN
  ,
  output logic                      PAR
`endif
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  logic [STAGES*WIDTH-1:0] cnt_q, cnt_d;
  logic [STAGES-1:0]       carry_q, carry_d;
  logic [1:0]              state_q, state_d;
  logic [WIDTH-1:0]        digit;
  logic                    adv_en;

  always_comb begin
    cnt_d   = cnt_q;
    carry_d = '0;
    state_d = state_q;
    digit   = '0;
    adv_en  = 1'b0;
    if (CLR) begin
      cnt_d   = '0;
      state_d = S_IDLE;
    end else if (LOAD) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        digit = LOAD_VAL[k*WIDTH +: WIDTH];
        cnt_d[k*WIDTH +: WIDTH] = (digit > LIM) ? LIM : digit;
      end
      if (state_q == S_IDLE && START) state_d = S_RUN;
    end else begin
      case (state_q)
        S_IDLE:  if (START) state_d = S_RUN;
        S_RUN: begin
          if (HOLD) begin
            state_d = S_PAUSE;
          end else begin
            // adv_en accumulates "all lower digits terminal" from the pre-edge count
            adv_en = 1'b1;
            for (int unsigned k = 0; k < STAGES; k++) begin
              digit = cnt_q[k*WIDTH +: WIDTH];
              if (adv_en) begin
                if (!DIR) begin
                  if (digit == LIM) begin
                    cnt_d[k*WIDTH +: WIDTH] = '0;
                    carry_d[k] = 1'b1;
                  end else begin
                    cnt_d[k*WIDTH +: WIDTH] = digit + 1'b1;
                  end
                end else begin
                  if (digit == '0) begin
                    cnt_d[k*WIDTH +: WIDTH] = LIM;
                    carry_d[k] = 1'b1;
                  end else begin
                    cnt_d[k*WIDTH +: WIDTH] = digit - 1'b1;
                  end
                end
              end
              adv_en = adv_en & (DIR ? (digit == '0) : (digit == LIM));
            end
            if (carry_d[STAGES-1]) state_d = (AUTO_RESTART != 0) ? S_RUN : S_DONE;
          end
        end
        S_PAUSE: if (!HOLD) state_d = S_RUN;
        S_DONE:  if (START) state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CK) begin
    if (!RSTN) begin
      cnt_q   <= '0;
      carry_q <= '0;
      state_q <= S_IDLE;
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      state_q <= state_d;
    end
  end

`ifdef CASCADE_PARITY_EN
  logic par_q, par_d;

  always_comb par_d = ^cnt_d;

  always_ff @(posedge CK) begin
    if (!RSTN) par_q <= 1'b0;
    else       par_q <= par_d;
  end

  assign PAR = par_q;
`endif

  assign CNT   = cnt_q;
  assign CARRY = carry_q;
  assign STATE = state_q;
  assign BUSY  = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign DONE  = (state_q == S_DONE);

endmodule

// File: tb/tb_cascade_counter_ctl.sv
// Scoreboard bench for cascade_counter_ctl: an arithmetic base-(LIMIT+1) model
// predicts each edge; a monitor process compares the DUT outputs one cycle later.
module tb_cascade_counter_ctl;
  localparam int STAGES = 3;
  localparam int WIDTH  = 4;
  localparam int LIMIT  = 9;
  localparam int AR     = 0;
  localparam int NB     = STAGES * WIDTH;
  localparam int P      = LIMIT + 1;

  logic CK = 1'b0;
  logic rstn = 1'b0, start = 1'b0, hold = 1'b0, clr = 1'b0, dir = 1'b0, load = 1'b0;
  logic [NB-1:0]     lv = '0;
  logic [NB-1:0]     cnt;
  logic [STAGES-1:0] carry;
  logic [1:0]        st;
  logic              busy, done_o;
`ifdef CASCADE_PARITY_EN
  logic              par;
`endif

  cascade_counter_ctl #(.STAGES(STAGES), .WIDTH(WIDTH), .LIMIT(LIMIT), .AUTO_RESTART(AR)) dut (
    .CK(CK), .RSTN(rstn), .START(start), .HOLD(hold), .CLR(clr), .DIR(dir),
    .LOAD(load), .LOAD_VAL(lv), .CNT(cnt), .CARRY(carry), .STATE(st),
    .BUSY(busy), .DONE(done_o)
`ifdef CASCADE_PARITY_EN
    , .PAR(par)
`endif
  );

  always #5 CK = ~CK;

  typedef struct {
    logic [NB-1:0]     cnt;
    logic [STAGES-1:0] carry;
    logic [1:0]        st;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // model: the whole count as one integer, state as IDLE=0 RUN=1 PAUSE=2 DONE=3
  int                m_total = 0;
  int                m_state = 0;
  logic [STAGES-1:0] m_carry = '0;

  function automatic int pw(int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * P;
    return r;
  endfunction

  function automatic logic [NB-1:0] to_cnt(int t);
    logic [NB-1:0] v = '0;
    for (int k = 0; k < STAGES; k++) v[k*WIDTH +: WIDTH] = WIDTH'((t / pw(k)) % P);
    return v;
  endfunction

  function automatic int from_lv(logic [NB-1:0] v);
    int t = 0;
    int d;
    for (int k = 0; k < STAGES; k++) begin
      d = int'(v[k*WIDTH +: WIDTH]);
      if (d > LIMIT) d = LIMIT;
      t = t + d * pw(k);
    end
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step();
    int m = pw(STAGES);
    m_carry = '0;
    if (!rstn || clr) begin
      m_total = 0;
      m_state = 0;
    end else if (load) begin
      m_total = from_lv(lv);
      if (m_state == 0 && start) m_state = 1;
    end else begin
      case (m_state)
        0: if (start) m_state = 1;
        1: if (hold) m_state = 2;
           else begin
             for (int k = 0; k < STAGES; k++)
               m_carry[k] = dir ? ((m_total % pw(k+1)) == 0)
                                : ((m_total % pw(k+1)) == pw(k+1) - 1);
             m_total = dir ? (m_total + m - 1) % m : (m_total + 1) % m;
             if (m_carry[STAGES-1]) m_state = (AR != 0) ? 1 : 3;
           end
        2: if (!hold) m_state = 1;
        default: if (start) m_state = 1;
      endcase
    end
  endtask

  task automatic cycle(input logic i_rstn, input logic i_start, input logic i_hold,
                       input logic i_clr, input logic i_dir, input logic i_load,
                       input logic [NB-1:0] i_lv);
    exp_t e;
    @(negedge CK);
    rstn = i_rstn; start = i_start; hold = i_hold; clr = i_clr;
    dir = i_dir; load = i_load; lv = i_lv;
    model_step();
    e.cnt = to_cnt(m_total);
    e.carry = m_carry;
    e.st = 2'(m_state);
    exp_q.push_back(e);
    @(posedge CK);
  endtask

  task automatic idle(input int n, input logic i_dir);
    repeat (n) cycle(1'b1, 1'b0, 1'b0, 1'b0, i_dir, 1'b0, '0);
  endtask

  always @(posedge CK) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cnt", 64'(cnt), 64'(e.cnt));
      check("carry", 64'(carry), 64'(e.carry));
      check("state", 64'(st), 64'(e.st));
      check("busy", 64'(busy), 64'(e.st == 2'b01 || e.st == 2'b10));
      check("done", 64'(done_o), 64'(e.st == 2'b11));
`ifdef CASCADE_PARITY_EN
      check("par", 64'(par), 64'(^e.cnt));
`endif
    end
  end

  initial begin
    logic r_dir;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    #1; check("reset_cnt", 64'(cnt), 64'h000); check("reset_state", 64'(st), 64'h0);

    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    #1; check("start_state", 64'(st), 64'h1); check("start_cnt_hold", 64'(cnt), 64'h000);
    idle(1, 1'b0);
    #1; check("first_adv", 64'(cnt), 64'h001);
    idle(998, 1'b0);
    #1; check("cnt_999", 64'(cnt), 64'h999);
    idle(1, 1'b0);
    #1; check("wrap_cnt", 64'(cnt), 64'h000); check("wrap_carry", 64'(carry), 64'h7);
    check("wrap_done", 64'(done_o), 64'h1);
    idle(3, 1'b0);
    #1; check("done_frozen", 64'(cnt), 64'h000); check("done_carry0", 64'(carry), 64'h0);

    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h100);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    idle(1, 1'b1);
    #1; check("down_cnt", 64'(cnt), 64'h099); check("down_carry", 64'(carry), 64'h3);

    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h047);
    repeat (5) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    #1; check("pause_state", 64'(st), 64'h2); check("pause_cnt", 64'(cnt), 64'h047);
    idle(1, 1'b0);
    #1; check("resume_no_adv", 64'(cnt), 64'h047);
    idle(1, 1'b0);
    #1; check("resume_adv", 64'(cnt), 64'h048);

    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0F5);
    #1; check("load_clamp", 64'(cnt), 64'h095);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h523);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    #1; check("clr_cnt", 64'(cnt), 64'h000); check("clr_state", 64'(st), 64'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h777);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h321);
    #1; check("rst_over_load", 64'(cnt), 64'h000);

    r_dir = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) r_dir = ~r_dir;
      cycle(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 99) == 0), r_dir,
            1'($urandom_range(0, 29) == 0), NB'($urandom));
    end
    idle(1, 1'b0);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
